// File: rtl/dp_sequencer.sv
// dp_sequencer -- control unit for the single-cycle Datapath_Module.
//
// Purpose:
//   LOAD  : host writes are steered to instruction or data memory.
//   CLEAR : one cycle with clr=1; the flag register and retired counter are zeroed.
//   RUN   : mem_instr_out[15:11] is decoded combinationally into datapath strobes.
//           ALU instructions load the {N,Z,C,V} flag register from Pre_*.
//           Conditional branches test the registered flags.
//   HALT  : entered on HLT; all strobes are low; left on host_start.
//
// Parameters:
//   WORD_W  instruction, data and address width (default 16)
//   CNT_W   retired-instruction counter width (default 16)
//
// Optional feature macro:
//   DP_SEQ_STEP_EN  when defined, RUN executes an instruction only in cycles
//                   where step=1. When undefined, step is ignored.
//
// Ports:
//   clk, clr_n                        clock, asynchronous active-low reset
//   host_valid/ready/is_data/addr/data/start
//                                     host load port
//   step                              single-step pulse (DP_SEQ_STEP_EN only)
//   mem_instr_out, Pre_C/V/Z/N        current instruction and its ALU flags
//   test_normal, ext_*                memory-load mode and host write path
//   clr, flag_HLT                     PC clear, PC-advance enable
//   ADC .. flag_OutR                  datapath control strobes
//   halted, retired                   status outputs
module dp_sequencer #(
    parameter int WORD_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic              host_is_data,
    input  logic [WORD_W-1:0] host_addr,
    input  logic [WORD_W-1:0] host_data,
    input  logic              host_start,
    input  logic              step,
    input  logic [15:0]       mem_instr_out,
    input  logic              Pre_C,
    input  logic              Pre_V,
    input  logic              Pre_Z,
    input  logic              Pre_N,
    output logic              test_normal,
    output logic              ext_instr_we,
    output logic              ext_data_write_en,
    output logic [WORD_W-1:0] ext_instr_addr,
    output logic [WORD_W-1:0] ext_instr_data,
    output logic [WORD_W-1:0] ext_data_addr,
    output logic [WORD_W-1:0] ext_data_data,
    output logic              clr,
    output logic              flag_HLT,
    output logic              ADC,
    output logic              SUB,
    output logic              SBB,
    output logic              JMP,
    output logic              BRANCH,
    output logic              Src_ALU_B,
    output logic              Src_Read_B,
    output logic              data_write_en,
    output logic              flag_mem_RF,
    output logic              flag_ALU_RF,
    output logic              flag_Rm_RF,
    output logic              flag_PC_RF,
    output logic              flag_label_PC,
    output logic              flag_Rm_PC,
    output logic              flag_Rd_PC,
    output logic              RF_write_en,
    output logic              LHI,
    output logic              LLI,
    output logic              flag_OutR,
    output logic              halted,
    output logic [CNT_W-1:0]  retired
);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [3:0]        r_flags;       // {N, Z, C, V}
    logic [CNT_W-1:0]  r_retired;
    logic [4:0]        w_opcode;
    logic              w_exec;        // an instruction retires this cycle
    logic              w_is_alu;
    logic              w_is_hlt;
    logic              w_cond;
    logic              w_host_i;
    logic              w_host_d;
    logic              w_unused;

    assign w_opcode = mem_instr_out[15:11];
    assign w_is_alu = (w_opcode == 5'b00000);
    assign w_is_hlt = (w_opcode == 5'b11111);
    assign w_host_i = host_valid & ~host_is_data;
    assign w_host_d = host_valid & host_is_data;
    // Operand fields are consumed by the datapath, not by this controller.
    assign w_unused = ^{mem_instr_out[7:2], step};

`ifdef DP_SEQ_STEP_EN
    assign w_exec = (r_state == ST_RUN) & step;
`else
    assign w_exec = (r_state == ST_RUN);
`endif

    // Branch condition evaluated on the registered flags, so a branch right
    // after an ALU instruction sees that instruction's result.
    always_comb begin
        w_cond = 1'b0;
        case (mem_instr_out[10:8])
            3'b000:  w_cond = r_flags[2];
            3'b001:  w_cond = ~r_flags[2];
            3'b010:  w_cond = r_flags[1];
            3'b011:  w_cond = ~r_flags[1];
            3'b100:  w_cond = r_flags[3];
            3'b101:  w_cond = ~r_flags[3];
            3'b110:  w_cond = r_flags[0];
            default: w_cond = 1'b1;
        endcase
    end

    // Next-state logic and all mode/strobe outputs.
    always_comb begin
        w_next_state      = r_state;
        host_ready        = 1'b0;
        test_normal       = 1'b0;
        ext_instr_we      = 1'b0;
        ext_data_write_en = 1'b0;
        ext_instr_addr    = {WORD_W{1'b0}};
        ext_instr_data    = {WORD_W{1'b0}};
        ext_data_addr     = {WORD_W{1'b0}};
        ext_data_data     = {WORD_W{1'b0}};
        clr               = 1'b0;
        flag_HLT          = 1'b0;
        halted            = 1'b0;
        ADC               = 1'b0;
        SUB               = 1'b0;
        SBB               = 1'b0;
        JMP               = 1'b0;
        BRANCH            = 1'b0;
        Src_ALU_B         = 1'b0;
        Src_Read_B        = 1'b0;
        data_write_en     = 1'b0;
        flag_mem_RF       = 1'b0;
        flag_ALU_RF       = 1'b0;
        flag_Rm_RF        = 1'b0;
        flag_PC_RF        = 1'b0;
        flag_label_PC     = 1'b0;
        flag_Rm_PC        = 1'b0;
        flag_Rd_PC        = 1'b0;
        RF_write_en       = 1'b0;
        LHI               = 1'b0;
        LLI               = 1'b0;
        flag_OutR         = 1'b0;
        case (r_state)
            ST_LOAD: begin
                host_ready        = 1'b1;
                test_normal       = 1'b1;
                ext_instr_we      = w_host_i;
                ext_data_write_en = w_host_d;
                ext_instr_addr    = w_host_i ? host_addr : {WORD_W{1'b0}};
                ext_instr_data    = w_host_i ? host_data : {WORD_W{1'b0}};
                ext_data_addr     = w_host_d ? host_addr : {WORD_W{1'b0}};
                ext_data_data     = w_host_d ? host_data : {WORD_W{1'b0}};
                w_next_state      = host_start ? ST_CLEAR : ST_LOAD;
            end
            ST_CLEAR: begin
                clr          = 1'b1;
                w_next_state = ST_RUN;
            end
            ST_RUN: begin
                case (w_opcode)
                    5'b00000: begin
                        flag_ALU_RF = 1'b1;
                        RF_write_en = 1'b1;
                        case (mem_instr_out[1:0])
                            2'b01:   ADC = 1'b1;
                            2'b10:   SUB = 1'b1;
                            2'b11:   SBB = 1'b1;
                            default: ADC = 1'b0;   // plain ADD
                        endcase
                    end
                    5'b00001: begin
                        LHI         = 1'b1;
                        Src_Read_B  = 1'b1;
                        RF_write_en = 1'b1;
                    end
                    5'b00010: begin
                        LLI         = 1'b1;
                        RF_write_en = 1'b1;
                    end
                    5'b00011: begin
                        Src_ALU_B   = 1'b1;
                        flag_mem_RF = 1'b1;
                        RF_write_en = 1'b1;
                    end
                    5'b00100: begin
                        flag_Rm_RF  = 1'b1;
                        RF_write_en = 1'b1;
                    end
                    5'b00101: begin
                        Src_ALU_B     = 1'b1;
                        Src_Read_B    = 1'b1;
                        data_write_en = 1'b1;
                    end
                    5'b11000: begin
                        flag_label_PC = 1'b1;
                        BRANCH        = w_cond;
                    end
                    5'b10000: begin
                        JMP        = 1'b1;
                        flag_Rm_PC = 1'b1;
                    end
                    5'b10001: begin
                        JMP           = 1'b1;
                        flag_label_PC = 1'b1;
                        flag_PC_RF    = 1'b1;
                        RF_write_en   = 1'b1;
                    end
                    5'b11100: flag_OutR = 1'b1;
                    default:  flag_OutR = 1'b0;   // HLT and unlisted opcodes
                endcase
                // Without an executing cycle nothing may be written back.
                RF_write_en   = RF_write_en & w_exec;
                data_write_en = data_write_en & w_exec;
                flag_HLT      = w_exec & ~w_is_hlt;
                w_next_state  = (w_exec & w_is_hlt) ? ST_HALT : ST_RUN;
            end
            ST_HALT: begin
                halted       = 1'b1;
                w_next_state = host_start ? ST_LOAD : ST_HALT;
            end
            default: w_next_state = ST_LOAD;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NZCV flag register: cleared in CLEAR, loaded by executed ALU instructions.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_flags <= 4'b0000;
        end else if (r_state == ST_CLEAR) begin
            r_flags <= 4'b0000;
        end else if (w_exec && w_is_alu) begin
            r_flags <= {Pre_N, Pre_Z, Pre_C, Pre_V};
        end else begin
            r_flags <= r_flags;
        end
    end

    // Saturating retired-instruction counter.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_retired <= {CNT_W{1'b0}};
        end else if (r_state == ST_CLEAR) begin
            r_retired <= {CNT_W{1'b0}};
        end else if (w_exec && (r_retired != {CNT_W{1'b1}})) begin
            r_retired <= r_retired + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_retired <= r_retired;
        end
    end

    assign retired = r_retired;

endmodule

// File: tb/tb_dp_sequencer.sv
// Directed testbench for dp_sequencer. The counter is built 5 bits wide so
// saturation at 31 is reachable in a short run.
module tb_dp_sequencer;

    localparam int WORD_W = 16;
    localparam int CNT_W  = 5;

    // Strobe vector bit positions
    localparam int B_ADC = 18, B_SUB = 17, B_SBB = 16, B_JMP = 15, B_BR = 14;
    localparam int B_SAB = 13, B_SRB = 12, B_DWE = 11, B_MRF = 10, B_ARF = 9;
    localparam int B_RMRF = 8, B_PCRF = 7, B_LPC = 6, B_RMPC = 5, B_RDPC = 4;
    localparam int B_RFWE = 3, B_LHI = 2, B_LLI = 1, B_OUT = 0;

    localparam logic [18:0] S_NONE = 19'd0;
    localparam logic [18:0] S_ALU  = (19'd1 << B_ARF) | (19'd1 << B_RFWE);
    localparam logic [18:0] S_SUB  = S_ALU | (19'd1 << B_SUB);
    localparam logic [18:0] S_ADC  = S_ALU | (19'd1 << B_ADC);
    localparam logic [18:0] S_SBB  = S_ALU | (19'd1 << B_SBB);
    localparam logic [18:0] S_LHI  = (19'd1 << B_LHI) | (19'd1 << B_SRB) | (19'd1 << B_RFWE);
    localparam logic [18:0] S_LLI  = (19'd1 << B_LLI) | (19'd1 << B_RFWE);
    localparam logic [18:0] S_LDR  = (19'd1 << B_SAB) | (19'd1 << B_MRF) | (19'd1 << B_RFWE);
    localparam logic [18:0] S_MOV  = (19'd1 << B_RMRF) | (19'd1 << B_RFWE);
    localparam logic [18:0] S_STR  = (19'd1 << B_SAB) | (19'd1 << B_SRB) | (19'd1 << B_DWE);
    localparam logic [18:0] S_BN   = (19'd1 << B_LPC);
    localparam logic [18:0] S_BT   = (19'd1 << B_LPC) | (19'd1 << B_BR);
    localparam logic [18:0] S_JMP  = (19'd1 << B_JMP) | (19'd1 << B_RMPC);
    localparam logic [18:0] S_JAL  = (19'd1 << B_JMP) | (19'd1 << B_LPC) | (19'd1 << B_PCRF) | (19'd1 << B_RFWE);
    localparam logic [18:0] S_OUT  = (19'd1 << B_OUT);

    logic clk = 1'b0;
    logic clr_n, host_valid, host_is_data, host_start, step;
    logic [WORD_W-1:0] host_addr, host_data;
    logic [15:0] mem_instr_out;
    logic Pre_C, Pre_V, Pre_Z, Pre_N;
    logic host_ready, test_normal, ext_instr_we, ext_data_write_en;
    logic [WORD_W-1:0] ext_instr_addr, ext_instr_data, ext_data_addr, ext_data_data;
    logic clr, flag_HLT, halted;
    logic ADC, SUB, SBB, JMP, BRANCH, Src_ALU_B, Src_Read_B, data_write_en;
    logic flag_mem_RF, flag_ALU_RF, flag_Rm_RF, flag_PC_RF, flag_label_PC;
    logic flag_Rm_PC, flag_Rd_PC, RF_write_en, LHI, LLI, flag_OutR;
    logic [CNT_W-1:0] retired;
    logic [18:0] strb;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_ret  = 0;

    dp_sequencer #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .clr_n(clr_n), .host_valid(host_valid), .host_ready(host_ready),
        .host_is_data(host_is_data), .host_addr(host_addr), .host_data(host_data),
        .host_start(host_start), .step(step), .mem_instr_out(mem_instr_out),
        .Pre_C(Pre_C), .Pre_V(Pre_V), .Pre_Z(Pre_Z), .Pre_N(Pre_N),
        .test_normal(test_normal), .ext_instr_we(ext_instr_we),
        .ext_data_write_en(ext_data_write_en), .ext_instr_addr(ext_instr_addr),
        .ext_instr_data(ext_instr_data), .ext_data_addr(ext_data_addr),
        .ext_data_data(ext_data_data), .clr(clr), .flag_HLT(flag_HLT),
        .ADC(ADC), .SUB(SUB), .SBB(SBB), .JMP(JMP), .BRANCH(BRANCH),
        .Src_ALU_B(Src_ALU_B), .Src_Read_B(Src_Read_B), .data_write_en(data_write_en),
        .flag_mem_RF(flag_mem_RF), .flag_ALU_RF(flag_ALU_RF), .flag_Rm_RF(flag_Rm_RF),
        .flag_PC_RF(flag_PC_RF), .flag_label_PC(flag_label_PC), .flag_Rm_PC(flag_Rm_PC),
        .flag_Rd_PC(flag_Rd_PC), .RF_write_en(RF_write_en), .LHI(LHI), .LLI(LLI),
        .flag_OutR(flag_OutR), .halted(halted), .retired(retired)
    );

    assign strb = {ADC, SUB, SBB, JMP, BRANCH, Src_ALU_B, Src_Read_B, data_write_en,
                   flag_mem_RF, flag_ALU_RF, flag_Rm_RF, flag_PC_RF, flag_label_PC,
                   flag_Rm_PC, flag_Rd_PC, RF_write_en, LHI, LLI, flag_OutR};

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Every output at its reset / LOAD-idle value.
    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ready"}, {31'd0, host_ready}, 32'd1);
        check_eq({tag, "_tnorm"}, {31'd0, test_normal}, 32'd1);
        check_eq({tag, "_clr"}, {31'd0, clr}, 32'd0);
        check_eq({tag, "_halted"}, {31'd0, halted}, 32'd0);
        check_eq({tag, "_fhlt"}, {31'd0, flag_HLT}, 32'd0);
        check_eq({tag, "_strb"}, {13'd0, strb}, 32'd0);
        check_eq({tag, "_we"}, {30'd0, ext_instr_we, ext_data_write_en}, 32'd0);
        check_eq({tag, "_bus"}, ext_instr_addr | ext_instr_data | ext_data_addr | ext_data_data, 32'd0);
        check_eq({tag, "_ret"}, {27'd0, retired}, 32'd0);
    endtask

    // Called at a negedge; drives one host write and checks the combinational path.
    task automatic host_wr(input logic is_d, input logic [15:0] a, input logic [15:0] d, input logic st);
        host_valid = 1'b1; host_is_data = is_d; host_addr = a; host_data = d; host_start = st;
        #1;
        check_eq("host_we", {30'd0, ext_instr_we, ext_data_write_en}, {30'd0, ~is_d, is_d});
        check_eq("host_addr", is_d ? ext_data_addr : ext_instr_addr, {16'd0, a});
        check_eq("host_data", is_d ? ext_data_data : ext_instr_data, {16'd0, d});
        @(negedge clk);
        host_valid = 1'b0; host_start = 1'b0; host_addr = 16'h0000; host_data = 16'h0000;
    endtask

    // Called at a negedge in RUN; applies one instruction, checks decode and retire count.
    task automatic run_instr(input string tag, input logic [15:0] ins, input logic [3:0] nzcv,
                             input logic [18:0] exp_s);
        mem_instr_out = ins;
        {Pre_N, Pre_Z, Pre_C, Pre_V} = nzcv;
        #1;
        check_eq({tag, "_strb"}, {13'd0, strb}, {13'd0, exp_s});
        check_eq({tag, "_fhlt"}, {31'd0, flag_HLT}, 32'd1);
        @(negedge clk);
        if (exp_ret < 31) exp_ret++;
        check_eq({tag, "_ret"}, {27'd0, retired}, exp_ret);
    endtask

    initial begin
        clr_n = 1'b0; host_valid = 1'b0; host_is_data = 1'b0; host_addr = 16'h0000;
        host_data = 16'h0000; host_start = 1'b0; step = 1'b1; mem_instr_out = 16'h0000;
        {Pre_N, Pre_Z, Pre_C, Pre_V} = 4'b0000;
        @(negedge clk); @(negedge clk);
        check_reset_outputs("rst");
        clr_n = 1'b1;

        // Load program and data; last write carries host_start
        @(negedge clk);
        host_wr(1'b0, 16'h0000, 16'h1900, 1'b0);
        host_wr(1'b0, 16'h0001, 16'hE040, 1'b0);
        host_wr(1'b1, 16'h0000, 16'h1234, 1'b1);

        // CLEAR cycle; host_start here must be ignored
        mem_instr_out = 16'h1900; host_start = 1'b1;
        #1;
        check_eq("clear_clr", {31'd0, clr}, 32'd1);
        check_eq("clear_tnorm", {31'd0, test_normal}, 32'd0);
        check_eq("clear_ready", {31'd0, host_ready}, 32'd0);
        check_eq("clear_strb", {13'd0, strb}, 32'd0);
        check_eq("clear_fhlt", {31'd0, flag_HLT}, 32'd0);
        @(negedge clk);
        host_start = 1'b0;
        check_eq("run_clr", {31'd0, clr}, 32'd0);

        run_instr("ldr", 16'h1900, 4'b0000, S_LDR);
        run_instr("out", 16'hE040, 4'b0000, S_OUT);
        check_eq("retired_2", {27'd0, retired}, 32'd2);
        run_instr("sub_eq", 16'h0002, 4'b0110, S_SUB);
        run_instr("beq_t", 16'hC000, 4'b0000, S_BT);   // Pre_Z=0 now: must use registered Z
        run_instr("bne_f", 16'hC100, 4'b0000, S_BN);
        run_instr("sub_ne", 16'h0002, 4'b1000, S_SUB);
        run_instr("beq_f", 16'hC000, 4'b0110, S_BN);
        run_instr("bne_t", 16'hC100, 4'b0000, S_BT);
        run_instr("bcs_f", 16'hC200, 4'b0000, S_BN);
        run_instr("bcc_t", 16'hC300, 4'b0000, S_BT);
        run_instr("bmi_t", 16'hC400, 4'b0000, S_BT);
        run_instr("bpl_f", 16'hC500, 4'b0000, S_BN);
        run_instr("add_v", 16'h0000, 4'b0001, S_ALU);
        run_instr("bvs_t", 16'hC600, 4'b0000, S_BT);
        run_instr("bal_t", 16'hC700, 4'b0000, S_BT);
        run_instr("adc", 16'h0001, 4'b0100, S_ADC);
        run_instr("sbb", 16'h0003, 4'b0100, S_SBB);
        run_instr("lhi", 16'h0800, 4'b0000, S_LHI);
        run_instr("lli", 16'h1000, 4'b0000, S_LLI);
        run_instr("mov", 16'h2000, 4'b0000, S_MOV);
        run_instr("str", 16'h2800, 4'b0000, S_STR);
        host_start = 1'b1;   // ignored in RUN
        run_instr("jmp", 16'h8000, 4'b0000, S_JMP);
        run_instr("jal", 16'h8800, 4'b0000, S_JAL);
        run_instr("nop", 16'h4000, 4'b0000, S_NONE);
        host_start = 1'b0;

        // HLT
        mem_instr_out = 16'hF800;
        #1;
        check_eq("hlt_strb", {13'd0, strb}, 32'd0);
        check_eq("hlt_fhlt", {31'd0, flag_HLT}, 32'd0);
        @(negedge clk);
        exp_ret++;
        check_eq("halt_halted", {31'd0, halted}, 32'd1);
        check_eq("halt_ret", {27'd0, retired}, 32'd25);
        mem_instr_out = 16'h0000; {Pre_N, Pre_Z, Pre_C, Pre_V} = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("halt_hold_ret", {27'd0, retired}, exp_ret);
            check_eq("halt_hold_out", {12'd0, halted, flag_HLT, strb}, {12'd0, 1'b1, 1'b0, 19'd0});
        end
        host_start = 1'b1;
        @(negedge clk);
        host_start = 1'b0;
        check_eq("halt2load", {29'd0, host_ready, test_normal, halted}, 32'b110);

        // Second run: flags and counter must have been cleared
        @(negedge clk);
        host_start = 1'b1;
        @(negedge clk);
        host_start = 1'b0;
        check_eq("clear2_clr", {31'd0, clr}, 32'd1);
        @(negedge clk);
        exp_ret = 0;
        run_instr("beq_cleared", 16'hC000, 4'b0000, S_BN);

`ifdef DP_SEQ_STEP_EN
        for (int i = 0; i < 12; i++) begin
            step = (i % 4 == 0);
            mem_instr_out = 16'h0000;
            #1;
            check_eq("step_rfwe", {31'd0, RF_write_en}, {31'd0, step});
            check_eq("step_fhlt", {31'd0, flag_HLT}, {31'd0, step});
            @(negedge clk);
        end
        exp_ret += 3;
        step = 1'b1;
        check_eq("step_ret", {27'd0, retired}, 32'd4);
`endif

        for (int i = 0; i < 40; i++) begin
            run_instr("nop_sat", 16'h4000, 4'b0000, S_NONE);
        end
        check_eq("sat_ret", {27'd0, retired}, 32'd31);

        // Asynchronous reset in the middle of RUN
        mem_instr_out = 16'h1900;
        #1;
        clr_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        clr_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
